coin_acceptor: RTL

- Front-end stage that feeds the vending FSM's coin input.
- Converts two raw mechanical coin-slot switches (5 rs, 10 rs) into clean coin events. Each event is a single-cycle code on coin_code: 01 = 5 rs, 10 = 10 rs, 00 = no coin.
- Synchronises, debounces, rejects illegal or overflow insertions, and buffers bursts in a small FIFO so that at most one coin is presented per cycle.

---
 rtl/coin_acceptor_if.sv | 40 ++++
 rtl/coin_acceptor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor_if.sv
// Coin-acceptor bus: raw slot switches and enable in, clean coin events
// and status counters out. The master side is the coin mechanism and
// machine controller; the slave side is the acceptor itself.
interface coin_acceptor_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
);

    logic                          coin5_raw;
    logic                          coin10_raw;
    logic                          accept_en;
    logic [1:0]                    coin_code;
    logic                          coin_reject;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic [CNT_W-1:0]              coin_count;
    logic [CNT_W-1:0]              reject_count;

    modport master (
        output coin5_raw,
        output coin10_raw,
        output accept_en,
        input  coin_code,
        input  coin_reject,
        input  fifo_level,
        input  coin_count,
        input  reject_count
    );

    modport slave (
        input  coin5_raw,
        input  coin10_raw,
        input  accept_en,
        output coin_code,
        output coin_reject,
        output fifo_level,
        output coin_count,
        output reject_count
    );

endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the two coin-slot
// switches, classifies each clean insertion as accepted or rejected, and
// queues accepted coins so the vending FSM sees at most one per cycle.
// Channel index 0 is the 5 rs slot, index 1 is the 10 rs slot.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int CNT_W           = 8
) (
    input  logic           clk,
    input  logic           rst,
    coin_acceptor_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [7:0]       DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_5    = 2'b01;
    localparam logic [1:0] CODE_10   = 2'b10;

    // Classification verdict for the current cycle.
    localparam logic [1:0] VERDICT_IDLE   = 2'd0;
    localparam logic [1:0] VERDICT_ACCEPT = 2'd1;
    localparam logic [1:0] VERDICT_REJECT = 2'd2;

    // ------------------------------------------------------------------
    // Synchroniser state. sync_vld_q marks when sync2_q holds a real
    // sample rather than its reset value, so arming cannot be fooled by
    // the zeros loaded at reset.
    // ------------------------------------------------------------------
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] sync_vld_q;

    // Two-flop synchroniser per channel plus the sample-valid shifter.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would
    // collapse the two stages into one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_vld_q <= '0;
        end else begin
            sync1_q    <= {bus.coin10_raw, bus.coin5_raw};
            sync2_q    <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Debounce and arming
    // ------------------------------------------------------------------
    logic [1:0][7:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]      stable_q, stable_d;
    logic [1:0]      stable_prev_q;
    logic [1:0]      armed_q, armed_d;

    // Count cycles of disagreement; toggle the stable level once the
    // disagreement has held for the full debounce window.
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        deb_cnt_d = '0;
        stable_d  = stable_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (sync2_q[ch] != stable_q[ch]) begin
                if (deb_cnt_q[ch] == DEB_LAST) begin
                    stable_d[ch] = ~stable_q[ch];
                end else begin
                    deb_cnt_d[ch] = deb_cnt_q[ch] + 8'd1;
                end
            end
        end
        armed_d = armed_q | (sync_vld_q[1] ? ~sync2_q : 2'b00);
    end

    // Debounce counters, stable levels, their one-cycle history and arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q     <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            armed_q       <= '0;
        end else begin
            deb_cnt_q     <= deb_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            armed_q       <= armed_d;
        end
    end

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    logic [1:0]       rise;
    logic [LVL_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       verdict;
    logic [1:0]       push_code;

    assign rise       = stable_q & ~stable_prev_q & armed_q;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_level == LVL_FULL);
    assign fifo_empty = (fifo_level == '0);

    // Decide what to do with a fresh insertion; first matching rule wins.
    always_comb begin
        verdict   = VERDICT_IDLE;
        push_code = CODE_NONE;
        if (rise == 2'b11) begin
            // Two coins dropped together: one reject for the pair.
            verdict = VERDICT_REJECT;
        end else if ((rise[0] && stable_q[1]) || (rise[1] && stable_q[0])) begin
            // A coin arrived while the other slot is still occupied.
            verdict = VERDICT_REJECT;
        end else if (rise != 2'b00) begin
            if (!bus.accept_en || fifo_full) begin
                verdict = VERDICT_REJECT;
            end else begin
                verdict   = VERDICT_ACCEPT;
                push_code = rise[0] ? CODE_5 : CODE_10;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO and output stage
    // ------------------------------------------------------------------
    logic [1:0]       fifo_mem [FIFO_DEPTH];
    logic             push;
    logic             pop;
    logic [1:0]       coin_code_q;
    logic             coin_reject_q;
    logic [CNT_W-1:0] coin_cnt_q;
    logic [CNT_W-1:0] reject_cnt_q;

    assign push = (verdict == VERDICT_ACCEPT);
    assign pop  = !fifo_empty;

    // Storage for buffered coin codes.
    // NOTE: the storage array has no reset; the pointers define which
    // entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_code;
        end
    end

    // Pointers, registered coin output, reject pulse and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            coin_code_q   <= CODE_NONE;
            coin_reject_q <= 1'b0;
            coin_cnt_q    <= '0;
            reject_cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + LVL_W'(1);
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + LVL_W'(1);
                coin_code_q <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
            end else begin
                coin_code_q <= CODE_NONE;
            end
            coin_reject_q <= (verdict == VERDICT_REJECT);
            if (push && coin_cnt_q != CNT_MAX) begin
                coin_cnt_q <= coin_cnt_q + CNT_W'(1);
            end
            if (verdict == VERDICT_REJECT && reject_cnt_q != CNT_MAX) begin
                reject_cnt_q <= reject_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.coin_code    = coin_code_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.fifo_level   = fifo_level;
    assign bus.coin_count   = coin_cnt_q;
    assign bus.reject_count = reject_cnt_q;

endmodule
